mbscore_intc: RTL
=================

MBSCORE_INTC -- requirements
Module: mbscore_intc

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt lines (1..16).
REQ-002 SHALL have parameter VECTOR_BASE, default 32'h0000_0080, handler base address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port irq_in  input  NUM_IRQ  device interrupt lines, level, rising edge = request.
REQ-006 SHALL have port mask_we  input  1  write strobe for the mask register.
REQ-007 SHALL have port mask_wdata  input  NUM_IRQ  new mask; 1 = line enabled.
REQ-008 SHALL have port int_en_n  input  1  register-file interrupt-blocked flag (spr[1][0]); 1 = block.
REQ-009 SHALL have port pc_valid  input  1  pc_in holds the PC of an interruptible instruction.
REQ-010 SHALL have port pc_in  input  32  current PC.
REQ-011 SHALL have port eret  input  1  one-cycle pulse, return from handler.
REQ-012 SHALL have port set_intr  output  1  one-cycle pulse to the register file (save EPC, set block flag).
REQ-013 SHALL have port epc_out  output  32  PC captured for spr[0].
REQ-014 SHALL have port vector_out  output  32  handler address, valid while set_intr is high.
REQ-015 SHALL have port irq_id  output  4  index of the line in service.
REQ-016 SHALL have port pending_out  output  NUM_IRQ  pending register.

Function
REQ-017 SHALL register irq_in into irq_d each cycle and treat irq_s & ~irq_d as an edge; each edge SHALL set its pending bit on the next posedge.
REQ-018 SHALL compute request = pending & mask, with mask updated on posedge when mask_we is high.
REQ-019 SHALL implement an FSM with states IDLE, ARB, ISSUE and SERVICE.
REQ-020 In IDLE, it SHALL go to ARB when request != 0, int_en_n == 0 and pc_valid == 1; otherwise it SHALL stay in IDLE.
REQ-021 In ARB, it SHALL latch into irq_id the lowest-index set bit of request and latch pc_in into epc_out; it SHALL then go to ISSUE.
REQ-022 In ISSUE, set_intr SHALL be 1 for exactly one cycle, vector_out SHALL equal VECTOR_BASE + (irq_id << 4), and pending[irq_id] SHALL be cleared; it SHALL then go to SERVICE.
REQ-023 In SERVICE, it SHALL wait for eret and go to IDLE on the cycle eret is high; eret in any other state SHALL be ignored.
REQ-024 Latency SHALL be exactly 2 cycles from the IDLE cycle in which the REQ-020 condition holds to set_intr high.
REQ-025 If an edge and the ISSUE clear hit the same pending bit in the same cycle, the set SHALL win.
REQ-026 A mask write during ARB, ISSUE or SERVICE SHALL NOT alter the latched irq_id; masked pending bits SHALL stay pending.
REQ-027 Only one interrupt SHALL be in service at a time; there SHALL be no nesting.
REQ-028 set_intr SHALL be a registered output; the register file samples it on the following negedge.

Reset
REQ-029 On rst, the FSM SHALL enter IDLE, and pending, mask, irq_d, the synchronizer flops, set_intr, epc_out, vector_out and irq_id SHALL all become 0.
REQ-030 Reset asserted mid-service SHALL abandon the service without emitting set_intr; after release the block SHALL be in IDLE with pending 0.

Configuration
REQ-031 With MBSCORE_INTC_SYNC_EN defined, irq_s SHALL be irq_in passed through a 2-flop synchronizer, so edge-to-pending is 3 cycles.
REQ-032 Without MBSCORE_INTC_SYNC_EN, irq_s SHALL equal irq_in, so edge-to-pending is 1 cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2 bits), the vector shift constant (4) and the default VECTOR_BASE.
REQ-034 The priority encoder SHALL be the sub-module mbscore_intc_prio (request in; index and any-bit-set out).

Verification
REQ-035 Scenario: mask = 8'h04, rising edge on irq_in[2], int_en_n = 0, pc_valid = 1, pc_in = 32'h0000_1000 -> set_intr pulses for 1 cycle, epc_out = 32'h1000, vector_out = 32'h0000_00A0, irq_id = 2, pending_out = 0.
REQ-036 Scenario: mask = 8'hFF, edges on lines 5 and 1 in the same cycle -> line 1 is serviced first (vector 32'h90); after eret, line 5 is serviced (vector 32'hD0).
REQ-037 Scenario: int_en_n = 1 while pending = 8'h01 -> no set_intr; on int_en_n dropping to 0 -> set_intr 2 cycles later.
REQ-038 Scenario: a new edge on line 3 in the ISSUE cycle that services line 3 -> pending_out[3] = 1 afterwards; line 3 is serviced again after eret.
REQ-039 Scenario: mask = 0, edge on line 0 -> pending_out = 8'h01 and no set_intr; mask write 8'h01 -> set_intr follows.
REQ-040 Scenario: rst pulse during SERVICE -> all outputs 0 and FSM in IDLE; eret after the reset produces no effect.

Source files
------------

// File: rtl/mbscore_intc_pkg.sv
// Shared constants for the mbscore interrupt controller: FSM encoding,
// vector spacing and the default handler base address.
package mbscore_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    localparam int          VEC_SHIFT           = 4;
    localparam logic [31:0] DEFAULT_VECTOR_BASE = 32'h0000_0080;

endpackage

// File: rtl/mbscore_intc_prio.sv
// Priority encoder: index of the lowest set request bit plus an any-set flag.
// Purely combinational.
module mbscore_intc_prio #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] request,
    output logic [3:0]         idx,
    output logic               any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = 4'd0;
        any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (request[i]) begin
                idx = 4'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbscore_intc.sv
// Edge-triggered, maskable, non-nesting interrupt controller; set_intr fires
// 2 cycles after an eligible IDLE cycle. Optional MBSCORE_INTC_SYNC_EN adds a 2-flop input synchronizer.
module mbscore_intc
    import mbscore_intc_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter logic [31:0] VECTOR_BASE = DEFAULT_VECTOR_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_en_n,
    input  logic               pc_valid,
    input  logic [31:0]        pc_in,
    input  logic               eret,
    output logic               set_intr,
    output logic [31:0]        epc_out,
    output logic [31:0]        vector_out,
    output logic [3:0]         irq_id,
    output logic [NUM_IRQ-1:0] pending_out
);

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] request;
    logic [NUM_IRQ-1:0] clr;
    logic [3:0]         prio_idx;
    logic               prio_any;
    logic               arb_load;
    logic [31:0]        vec_calc;
    state_t             state;
    state_t             state_nx;

`ifdef MBSCORE_INTC_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1;
    logic [NUM_IRQ-1:0] sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq_in;
`endif

    assign rise    = irq_s & ~irq_d;
    assign request = pending & mask;

    mbscore_intc_prio #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .request (request),
        .idx     (prio_idx),
        .any     (prio_any)
    );

    assign vec_calc = VECTOR_BASE + (32'(prio_idx) << VEC_SHIFT);

    always_comb begin
        state_nx = state;
        arb_load = 1'b0;
        clr      = '0;
        case (state)
            ST_IDLE: begin
                if ((|request) && !int_en_n && pc_valid)
                    state_nx = ST_ARB;
            end
            ST_ARB: begin
                // A mask write landing in the same cycle can empty request;
                // fall back to IDLE rather than vector to a masked line.
                if (prio_any) begin
                    arb_load = 1'b1;
                    state_nx = ST_ISSUE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                clr      = NUM_IRQ'(1) << irq_id;
                state_nx = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (eret)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            irq_d      <= '0;
            pending    <= '0;
            mask       <= '0;
            set_intr   <= 1'b0;
            epc_out    <= '0;
            vector_out <= '0;
            irq_id     <= '0;
        end else begin
            state    <= state_nx;
            irq_d    <= irq_s;
            // OR-ing the edge last lets a fresh request survive the service clear.
            pending  <= (pending & ~clr) | rise;
            set_intr <= arb_load;
            if (mask_we)
                mask <= mask_wdata;
            if (arb_load) begin
                irq_id     <= prio_idx;
                epc_out    <= pc_in;
                vector_out <= vec_calc;
            end
        end
    end

    assign pending_out = pending;

endmodule
